// File: rtl/tdc_hit_capture.sv
// TDC hit capture: timestamps filtered hits with {coarse counter, fine popcount}
// and queues the words in a small FIFO with a valid/ready read port.
//
// Ports:
//   clk         system clock (only clock)
//   rst         asynchronous active-high reset
//   hit_valid   filtered hit qualifier (level, clk-synchronous)
//   therm_code  sampled delay-line taps, bit 0 = first tap
//   out_data    head timestamp word {coarse, fine}
//   out_valid   FIFO non-empty
//   out_ready   consumer accepts the head word
//   ovf         sticky overflow flag
//   drop_cnt    saturating count of dropped hits
//   clr_ovf     synchronous clear of ovf and drop_cnt
module tdc_hit_capture #(
  parameter int NTAPS    = 64,
  parameter int COARSE_W = 16,
  parameter int FINE_W   = 7,
  parameter int DEPTH    = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       hit_valid,
  input  logic [NTAPS-1:0]           therm_code,
  output logic [COARSE_W+FINE_W-1:0] out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       ovf,
  output logic [7:0]                 drop_cnt,
  input  logic                       clr_ovf
);

  localparam int W  = COARSE_W + FINE_W;
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [COARSE_W-1:0] coarse;
  logic                hit_d;
  logic                hit_evt;

  logic                v1;
  logic [COARSE_W-1:0] c1;
  logic [NTAPS-1:0]    t1;

  logic                v2;
  logic [W-1:0]        w2;
  logic [FINE_W-1:0]   fine;

  logic [W-1:0]        mem [DEPTH];
  logic [AW:0]         wp;
  logic [AW:0]         rp;
  logic                full;
  logic                empty;
  logic                push;
  logic                pop;
  logic                drop;

  assign hit_evt = hit_valid & ~hit_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      coarse <= '0;
      hit_d  <= 1'b0;
    end else begin
      coarse <= coarse + 1'b1;
      hit_d  <= hit_valid;
    end
  end

  // S1: capture coarse time and raw taps on the event cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0;
      c1 <= '0;
      t1 <= '0;
    end else begin
      v1 <= hit_evt;
      if (hit_evt) begin
        c1 <= coarse;
        t1 <= therm_code;
      end
    end
  end

  // Counting ones rather than locating the 1->0 transition makes the
  // fine code immune to bubbles in the sampled thermometer.
  always_comb begin
    fine = '0;
    for (int i = 0; i < NTAPS; i++)
      fine = fine + FINE_W'(t1[i]);
  end

  // S2: register the assembled timestamp word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2 <= 1'b0;
      w2 <= '0;
    end else begin
      v2 <= v1;
      if (v1)
        w2 <= {c1, fine};
    end
  end

  // S3: FIFO write; full is judged before any same-cycle pop
  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) &&
                 (wp[AW-1:0] == rp[AW-1:0]);
  assign push  = v2 & ~full;
  assign drop  = v2 & full;
  assign pop   = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (push)
      mem[wp[AW-1:0]] <= w2;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push)
        wp <= wp + PTR_ONE;
      if (pop)
        rp <= rp + PTR_ONE;
    end
  end

  assign out_valid = ~empty;
  assign out_data  = out_valid ? mem[rp[AW-1:0]] : '0;

  // A drop in the same cycle as a clear restarts the count at one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      ovf <= 1'b1;
      if (clr_ovf)
        drop_cnt <= 8'd1;
      else if (drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 8'd1;
    end else if (clr_ovf) begin
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end
  end

endmodule

// File: doc/tdc_hit_capture.md
Name: tdc_hit_capture

Overview:
- Consumes the synchronised, one-shot stop/hit qualifier from the upstream hit filter stage and timestamps each hit.
- For each hit, latches the free-running coarse counter and the sampled tapped-delay-line thermometer code.
- Encodes the thermometer code to a fine value and queues {coarse, fine} words in a small FIFO with a valid/ready read port toward readout.

Parameters:
- NTAPS, 64, delay-line taps in the thermometer code
- COARSE_W, 16, coarse counter width
- FINE_W, 7, fine code width; must satisfy 2^FINE_W > NTAPS
- DEPTH, 4, output FIFO depth; power of two, at least 2

Ports:
- clk  in  1  system clock; the only clock
- rst  in  1  asynchronous, active-high reset
- hit_valid  in  1  filtered hit qualifier from the hit filter stage; level, synchronous to clk
- therm_code  in  NTAPS  delay-line taps sampled on clk; bit 0 is the first tap
- out_data  out  COARSE_W+FINE_W  timestamp word {coarse, fine}
- out_valid  out  1  out_data is valid
- out_ready  in  1  consumer accepts the word
- ovf  out  1  sticky FIFO overflow flag
- drop_cnt  out  8  saturating count of dropped hits
- clr_ovf  in  1  synchronous clear of ovf and drop_cnt

Behaviour:
- Reset values: all of the following are 0 while rst=1 and on release: coarse counter, edge register, pipeline valids, FIFO pointers, out_valid, out_data, ovf, drop_cnt.
- Reset asserted mid-operation discards all in-flight and queued hits.
- Coarse counter increments by 1 every clk and wraps from 2^COARSE_W-1 to 0.
- Hit detection: hit_d is hit_valid registered.
  - A hit event occurs on any cycle where hit_valid=1 and hit_d=0.
  - A level held high for N cycles produces exactly one event.
  - Back-to-back events need at least one low cycle between them.
- S1 (event cycle T): register coarse counter value at cycle T (pre-increment) and therm_code at cycle T; set v1.
- S2 (T+1): fine = popcount(therm_code), computed bubble-tolerantly.
  - Result range is 0..NTAPS, zero-extended to FINE_W.
  - Register {coarse, fine}; set v2.
- S3 (T+2): if v2=1 and the FIFO is not full, write the word. Otherwise drop it.
- Full is evaluated on the state at the start of the cycle. A pop in the same cycle does not rescue a push into a full FIFO.
- FIFO read side:
  - out_valid=1 whenever the FIFO is non-empty; out_data shows the head entry combinationally from storage.
  - A pop occurs when out_valid=1 and out_ready=1.
  - Simultaneous push and pop on a non-full, non-empty FIFO keeps occupancy constant.
  - Pointers wrap modulo DEPTH; full/empty use an extra pointer bit.
- Latency: with an empty FIFO, out_valid rises at cycle T+3 (first clk edge after the S3 write). Words leave in FIFO order, which is event order.
- Holding: out_data and out_valid stay stable while out_valid=1 and out_ready=0.
- Overflow:
  - A drop sets ovf=1 and increments drop_cnt, saturating at 255.
  - clr_ovf=1 clears both next cycle.
  - If a drop and clr_ovf occur in the same cycle, the drop wins: ovf=1 and drop_cnt=1.
- Hold-off: hit_valid transitions during the S1–S3 pipeline are independent. The pipeline accepts one event per two cycles with no stall.

Test Plan:
- Reset release, then single hit_valid pulse at a cycle where coarse=0x0010, therm_code with lowest 23 bits set -> out_valid at T+3, out_data={0x0010, 7'd23}; after out_ready=1 for one cycle, out_valid=0.
- hit_valid held high 10 cycles -> exactly one word produced; drop_cnt=0.
- out_ready=0, 6 events spaced 2 cycles apart -> 4 words queued in order, ovf=1, drop_cnt=2; pulse clr_ovf -> ovf=0, drop_cnt=0; drain -> first four coarse values in ascending order.
- Coarse wrap: event when coarse=0xFFFF, next event 3 cycles later -> words carry 0xFFFF then 0x0002; bubbly therm_code 0b1011 -> fine=3.
- Full FIFO with out_ready=1 and push in the same cycle -> push dropped (drop_cnt+1), occupancy DEPTH-1 next cycle; simultaneous drop and clr_ovf -> ovf=1, drop_cnt=1.
- rst asserted while 2 words are queued and 1 word is in S2 -> out_valid=0 immediately; after release no stale words appear and coarse restarts at 0.
